// File: rtl/pmem_hs.sv
// Handshaked unified memory: one instruction-fetch read port and one load/store port,
// each with valid/ready request/response channels and a programmable access latency.
module pmem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IF_LATENCY = 1,
  parameter int LS_LATENCY = 1,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_resp_valid,
  input  logic                  if_resp_ready,
  output logic [DATA_WIDTH-1:0] if_resp_data,
  output logic                  if_resp_err,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic                  ls_req_we,
  input  logic [1:0]            ls_req_size,
  input  logic [ADDR_WIDTH-1:0] ls_req_addr,
  input  logic [DATA_WIDTH-1:0] ls_req_wdata,
  output logic                  ls_resp_valid,
  input  logic                  ls_resp_ready,
  output logic [DATA_WIDTH-1:0] ls_resp_rdata,
  output logic                  ls_resp_err,
  output logic [1:0]            if_state_dbg,
  output logic [1:0]            ls_state_dbg,
  output logic [15:0]           dbg_fetch_cnt,
  output logic [15:0]           dbg_read_cnt,
  output logic [15:0]           dbg_write_cnt
);

  // Handshake: a request transfers on an edge where req_valid & req_ready are both high;
  // a response transfers on an edge where resp_valid & resp_ready are both high.

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

  localparam int MEM_WORDS = 1 << MEM_AW;
  localparam int IF_CW = (IF_LATENCY > 2) ? $clog2(IF_LATENCY - 1) : 1;
  localparam int LS_CW = (LS_LATENCY > 2) ? $clog2(LS_LATENCY - 1) : 1;
  // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2 and the access fires at zero.
  localparam logic [IF_CW-1:0] IF_CNT_INIT = IF_CW'((IF_LATENCY >= 2) ? IF_LATENCY - 2 : 0);
  localparam logic [LS_CW-1:0] LS_CNT_INIT = LS_CW'((LS_LATENCY >= 2) ? LS_LATENCY - 2 : 0);

  logic [DATA_WIDTH-1:0] mem [0:MEM_WORDS-1];

  state_t                if_state, ls_state;
  logic [IF_CW-1:0]      if_cnt;
  logic [LS_CW-1:0]      ls_cnt;
  logic [ADDR_WIDTH-1:0] if_addr_q, ls_addr_q;
  logic                  ls_we_q;
  logic [1:0]            ls_size_q;
  logic [DATA_WIDTH-1:0] ls_wdata_q;

  logic                  if_accept, if_access, if_eff_err, if_do;
  logic [ADDR_WIDTH-1:0] if_eff_addr;
  logic [MEM_AW-1:0]     if_idx;
  logic [DATA_WIDTH-1:0] if_word;

  logic                  ls_accept, ls_access, ls_eff_err, ls_eff_we, ls_rd_do, ls_wr_do;
  logic [ADDR_WIDTH-1:0] ls_eff_addr;
  logic [1:0]            ls_eff_size, ls_off;
  logic [DATA_WIDTH-1:0] ls_eff_wdata, ls_wdata_sh, ls_old, ls_new, ls_rd_raw, ls_rd_data;
  logic [3:0]            ls_be, ls_be_sh;
  logic [MEM_AW-1:0]     ls_idx;
  logic                  unused_addr_bits;

  assign if_accept   = if_req_valid & if_req_ready;
  assign if_access   = (if_state == ST_IDLE && if_accept && IF_LATENCY == 1) ||
                       (if_state == ST_WAIT && if_cnt == '0);
  assign if_eff_addr = (if_state == ST_IDLE) ? if_req_addr : if_addr_q;
  assign if_eff_err  = (if_eff_addr[1:0] != 2'b00);
  assign if_do       = if_access & ~if_eff_err;
  assign if_idx      = if_eff_addr[MEM_AW+1:2];

  assign ls_accept    = ls_req_valid & ls_req_ready;
  assign ls_access    = (ls_state == ST_IDLE && ls_accept && LS_LATENCY == 1) ||
                        (ls_state == ST_WAIT && ls_cnt == '0);
  assign ls_eff_addr  = (ls_state == ST_IDLE) ? ls_req_addr  : ls_addr_q;
  assign ls_eff_we    = (ls_state == ST_IDLE) ? ls_req_we    : ls_we_q;
  assign ls_eff_size  = (ls_state == ST_IDLE) ? ls_req_size  : ls_size_q;
  assign ls_eff_wdata = (ls_state == ST_IDLE) ? ls_req_wdata : ls_wdata_q;
  assign ls_off       = ls_eff_addr[1:0];
  assign ls_idx       = ls_eff_addr[MEM_AW+1:2];
  assign ls_eff_err   = (ls_eff_size == 2'd3) || (ls_eff_size == 2'd1 && ls_off[0]) ||
                        (ls_eff_size == 2'd2 && ls_off != 2'b00);
  assign ls_rd_do     = ls_access & ~ls_eff_err & ~ls_eff_we;
  assign ls_wr_do     = ls_access & ~ls_eff_err & ls_eff_we;

  assign unused_addr_bits = ^{if_eff_addr[ADDR_WIDTH-1:MEM_AW+2], ls_eff_addr[ADDR_WIDTH-1:MEM_AW+2]};

  always_comb begin
    ls_be = 4'b1111;
    case (ls_eff_size)
      2'd0:    ls_be = 4'b0001;
      2'd1:    ls_be = 4'b0011;
      default: ls_be = 4'b1111;
    endcase
    ls_be_sh    = ls_be << ls_off;
    ls_wdata_sh = ls_eff_wdata << {ls_off, 3'b000};
    ls_old      = mem[ls_idx];
    ls_new      = ls_old;
    for (int b = 0; b < 4; b++) begin
      if (ls_be_sh[b]) ls_new[8*b +: 8] = ls_wdata_sh[8*b +: 8];
    end
    ls_rd_raw  = ls_old >> {ls_off, 3'b000};
    ls_rd_data = ls_rd_raw;
    case (ls_eff_size)
      2'd0:    ls_rd_data = {{(DATA_WIDTH-8){1'b0}}, ls_rd_raw[7:0]};
      2'd1:    ls_rd_data = {{(DATA_WIDTH-16){1'b0}}, ls_rd_raw[15:0]};
      default: ls_rd_data = ls_rd_raw;
    endcase
    // A store landing on the same edge is visible to the fetch of that word.
    if_word = (ls_wr_do && ls_idx == if_idx) ? ls_new : mem[if_idx];
  end

  always_ff @(posedge clk) begin
    if (ls_wr_do) mem[ls_idx] <= ls_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_state      <= ST_IDLE;
      if_req_ready  <= 1'b1;
      if_resp_valid <= 1'b0;
      if_resp_data  <= '0;
      if_resp_err   <= 1'b0;
      if_cnt        <= '0;
      if_addr_q     <= '0;
    end else begin
      case (if_state)
        ST_IDLE: if (if_accept) begin
          if_addr_q    <= if_req_addr;
          if_req_ready <= 1'b0;
          if (if_access) begin
            if_resp_valid <= 1'b1;
            if_resp_data  <= if_eff_err ? '0 : if_word;
            if_resp_err   <= if_eff_err;
            if_state      <= ST_RESP;
          end else begin
            if_cnt   <= IF_CNT_INIT;
            if_state <= ST_WAIT;
          end
        end
        ST_WAIT: if (if_cnt != '0) begin
          if_cnt <= if_cnt - 1'b1;
        end else begin
          if_resp_valid <= 1'b1;
          if_resp_data  <= if_eff_err ? '0 : if_word;
          if_resp_err   <= if_eff_err;
          if_state      <= ST_RESP;
        end
        ST_RESP: if (if_resp_ready) begin
          if_resp_valid <= 1'b0;
          if_resp_data  <= '0;
          if_resp_err   <= 1'b0;
          if_req_ready  <= 1'b1;
          if_state      <= ST_IDLE;
        end
        default: begin
          if_state     <= ST_IDLE;
          if_req_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_state      <= ST_IDLE;
      ls_req_ready  <= 1'b1;
      ls_resp_valid <= 1'b0;
      ls_resp_rdata <= '0;
      ls_resp_err   <= 1'b0;
      ls_cnt        <= '0;
      ls_addr_q     <= '0;
      ls_we_q       <= 1'b0;
      ls_size_q     <= 2'd0;
      ls_wdata_q    <= '0;
    end else begin
      case (ls_state)
        ST_IDLE: if (ls_accept) begin
          ls_addr_q    <= ls_req_addr;
          ls_we_q      <= ls_req_we;
          ls_size_q    <= ls_req_size;
          ls_wdata_q   <= ls_req_wdata;
          ls_req_ready <= 1'b0;
          if (ls_access) begin
            ls_resp_valid <= 1'b1;
            ls_resp_rdata <= ls_rd_do ? ls_rd_data : '0;
            ls_resp_err   <= ls_eff_err;
            ls_state      <= ST_RESP;
          end else begin
            ls_cnt   <= LS_CNT_INIT;
            ls_state <= ST_WAIT;
          end
        end
        ST_WAIT: if (ls_cnt != '0) begin
          ls_cnt <= ls_cnt - 1'b1;
        end else begin
          ls_resp_valid <= 1'b1;
          ls_resp_rdata <= ls_rd_do ? ls_rd_data : '0;
          ls_resp_err   <= ls_eff_err;
          ls_state      <= ST_RESP;
        end
        ST_RESP: if (ls_resp_ready) begin
          ls_resp_valid <= 1'b0;
          ls_resp_rdata <= '0;
          ls_resp_err   <= 1'b0;
          ls_req_ready  <= 1'b1;
          ls_state      <= ST_IDLE;
        end
        default: begin
          ls_state     <= ST_IDLE;
          ls_req_ready <= 1'b1;
        end
      endcase
    end
  end

  // Access counters stand in for the backing-store call counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_fetch_cnt <= '0;
      dbg_read_cnt  <= '0;
      dbg_write_cnt <= '0;
    end else begin
      if (if_do)    dbg_fetch_cnt <= dbg_fetch_cnt + 16'd1;
      if (ls_rd_do) dbg_read_cnt  <= dbg_read_cnt + 16'd1;
      if (ls_wr_do) dbg_write_cnt <= dbg_write_cnt + 16'd1;
    end
  end

  assign if_state_dbg = if_state;
  assign ls_state_dbg = ls_state;

endmodule
